// File: rtl/gshare_predictor_pkg.sv
// gshare_predictor_pkg: shared definitions for the gshare direction predictor.
//   TRUE / FALSE  : single-bit boolean constants
//   bp_state_e    : table-init FSM states (ST_INIT while clearing the table, ST_RUN afterwards)
package gshare_predictor_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_e;

endpackage

// File: rtl/gshare_predictor_sat_ctr.sv
// bp_sat_ctr: next value of a CTR_W-bit saturating counter.
//   ctr      in  CTR_W  current counter value
//   taken    in  1      resolved direction (1 = count up, 0 = count down)
//   ctr_nxt  out CTR_W  updated value, clamped at 0 and all-ones
module bp_sat_ctr #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             taken,
   output logic [CTR_W-1:0] ctr_nxt
);

   localparam logic [CTR_W-1:0] CTR_MAX = '1;

   always_comb begin
      ctr_nxt = ctr;
      if (taken) begin
         if (ctr != CTR_MAX) ctr_nxt = ctr + 1'b1;
      end else begin
         if (ctr != '0) ctr_nxt = ctr - 1'b1;
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare branch direction predictor.
// A table of saturating counters indexed by (PC index bits ^ global history).
// Lookup is combinational for the fetcher; training and history repair come
// from the ROB at commit. After reset a walker FSM writes every entry to
// weakly-not-taken before predictions are enabled.
//   clk, rst                  clock, synchronous active-high reset
//   rdy                       global enable; low freezes every register
//   in_fetch_valid/_tag       fetch consumes a prediction for this index
//   out_fetch_taken           predicted direction (combinational)
//   out_fetch_ghr             history before this prediction (carried to ROB)
//   out_ready                 table initialised, predictions meaningful
//   in_rob_valid/_tag/_ghr    committing conditional branch and its fetch-time history
//   in_rob_taken/_mispredict  resolved direction, and whether it was mispredicted
//   out_mispred_cnt           saturating count of committed mispredicts
module gshare_predictor
   import gshare_predictor_pkg::*;
#(
   parameter int IDX_W  = 8,
   parameter int HIST_W = 8,
   parameter int CTR_W  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              in_fetch_valid,
   input  logic [IDX_W-1:0]  in_fetch_tag,
   output logic              out_fetch_taken,
   output logic [HIST_W-1:0] out_fetch_ghr,
   output logic              out_ready,
   input  logic              in_rob_valid,
   input  logic [IDX_W-1:0]  in_rob_tag,
   input  logic [HIST_W-1:0] in_rob_ghr,
   input  logic              in_rob_taken,
   input  logic              in_rob_mispredict,
   output logic [CNT_W-1:0]  out_mispred_cnt
);

   localparam int              ENTRIES = 2**IDX_W;
   localparam logic [CTR_W-1:0] WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

   bp_state_e         state;
   logic [IDX_W-1:0]  init_idx;
   logic [HIST_W-1:0] ghr;
   logic [HIST_W-1:0] ghr_shift;   // history after a speculative fetch
   logic [HIST_W-1:0] ghr_repair;  // history rebuilt from the mispredicted branch
   logic [CTR_W-1:0]  tbl [ENTRIES];

   logic [IDX_W-1:0]  ghr_ext, rob_ghr_ext;
   logic [IDX_W-1:0]  f_idx, u_idx;
   logic [CTR_W-1:0]  u_ctr, u_ctr_nxt;
   logic              run, fire_fetch, fire_commit, fire_repair;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [CTR_W-1:0]  wr_data;

   // Fit history to the index width: truncate long histories, zero-extend short ones.
   generate
      if (HIST_W >= IDX_W) begin : g_hist_trunc
         assign ghr_ext     = ghr[IDX_W-1:0];
         assign rob_ghr_ext = in_rob_ghr[IDX_W-1:0];
      end else begin : g_hist_zext
         assign ghr_ext     = {{(IDX_W-HIST_W){1'b0}}, ghr};
         assign rob_ghr_ext = {{(IDX_W-HIST_W){1'b0}}, in_rob_ghr};
      end

      if (HIST_W == 1) begin : g_hist_one
         assign ghr_shift  = out_fetch_taken;
         assign ghr_repair = in_rob_taken;
      end else begin : g_hist_multi
         assign ghr_shift  = {ghr[HIST_W-2:0], out_fetch_taken};
         assign ghr_repair = {in_rob_ghr[HIST_W-2:0], in_rob_taken};
      end
   endgenerate

   assign run             = (state == ST_RUN);
   assign out_ready       = run ? TRUE : FALSE;
   assign f_idx           = in_fetch_tag ^ ghr_ext;
   assign out_fetch_taken = run & tbl[f_idx][CTR_W-1];
   assign out_fetch_ghr   = ghr;

   assign fire_fetch  = run & rdy & in_fetch_valid;
   assign fire_commit = run & rdy & in_rob_valid;
   assign fire_repair = fire_commit & in_rob_mispredict;

   assign u_idx = in_rob_tag ^ rob_ghr_ext;
   assign u_ctr = tbl[u_idx];

   bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
      .ctr     (u_ctr),
      .taken   (in_rob_taken),
      .ctr_nxt (u_ctr_nxt)
   );

   // Single table write port: init walker owns it in ST_INIT, commit training in ST_RUN.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = u_idx;
      wr_data = u_ctr_nxt;
      if (!rst && rdy) begin
         if (!run) begin
            wr_en   = 1'b1;
            wr_idx  = init_idx;
            wr_data = WEAK_NT;
         end else if (in_rob_valid) begin
            wr_en = 1'b1;
         end
      end
   end

   // Table has no reset: the init walker establishes its contents.
   always_ff @(posedge clk) begin
      if (wr_en) tbl[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_INIT;
         init_idx        <= '0;
         ghr             <= '0;
         out_mispred_cnt <= '0;
      end else if (rdy) begin
         if (!run) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == IDX_W'(ENTRIES-1)) state <= ST_RUN;
         end
         // Repair wins over a same-cycle speculative shift.
         if (fire_repair)     ghr <= ghr_repair;
         else if (fire_fetch) ghr <= ghr_shift;
         if (fire_repair && out_mispred_cnt != '1)
            out_mispred_cnt <= out_mispred_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor (IDX_W=4, HIST_W=8, CTR_W=2, CNT_W=2).
// A reference model of counters, history and stats is stepped once per clock
// and every output is compared against it each cycle, plus directed checks.
module tb_gshare_predictor;

   localparam int IDX_W  = 4;
   localparam int HIST_W = 8;
   localparam int CTR_W  = 2;
   localparam int CNT_W  = 2;
   localparam int N      = 16;

   logic              clk = 1'b0;
   logic              rst, rdy;
   logic              fv;
   logic [IDX_W-1:0]  f_tag;
   logic              out_fetch_taken;
   logic [HIST_W-1:0] out_fetch_ghr;
   logic              out_ready;
   logic              rv;
   logic [IDX_W-1:0]  r_tag;
   logic [HIST_W-1:0] r_ghr;
   logic              r_taken, r_mis;
   logic [CNT_W-1:0]  out_mispred_cnt;

   always #5 clk = ~clk;

   gshare_predictor #(
      .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .CNT_W(CNT_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .rdy               (rdy),
      .in_fetch_valid    (fv),
      .in_fetch_tag      (f_tag),
      .out_fetch_taken   (out_fetch_taken),
      .out_fetch_ghr     (out_fetch_ghr),
      .out_ready         (out_ready),
      .in_rob_valid      (rv),
      .in_rob_tag        (r_tag),
      .in_rob_ghr        (r_ghr),
      .in_rob_taken      (r_taken),
      .in_rob_mispredict (r_mis),
      .out_mispred_cnt   (out_mispred_cnt)
   );

   // reference model: counters as plain integers 0..3
   int m_tbl [N];
   int m_ghr, m_cnt, m_init;
   bit m_ready;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int m_pred();
      if (!m_ready) return 0;
      return (m_tbl[(int'(f_tag) ^ m_ghr) % N] >= 2) ? 1 : 0;
   endfunction

   // Check outputs for the currently driven inputs, clock once, advance the model.
   task automatic step();
      int pred, ng, u;
      #1;
      pred = m_pred();
      chk("ready", out_ready, m_ready);
      chk("taken", out_fetch_taken, pred);
      chk("ghr",   out_fetch_ghr, m_ghr);
      chk("cnt",   out_mispred_cnt, m_cnt);
      @(posedge clk);
      if (rst) begin
         m_ready = 0; m_init = 0; m_ghr = 0; m_cnt = 0;
      end else if (rdy) begin
         if (!m_ready) begin
            m_tbl[m_init] = 1;
            m_init++;
            if (m_init == N) m_ready = 1;
         end else begin
            ng = m_ghr;
            if (fv) ng = ((m_ghr * 2) + pred) % 256;
            if (rv) begin
               u = (int'(r_tag) ^ int'(r_ghr)) % N;
               if (r_taken) m_tbl[u] = (m_tbl[u] < 3) ? m_tbl[u] + 1 : 3;
               else         m_tbl[u] = (m_tbl[u] > 0) ? m_tbl[u] - 1 : 0;
               if (r_mis) begin
                  ng = ((int'(r_ghr) * 2) + int'(r_taken)) % 256;
                  if (m_cnt < 3) m_cnt++;
               end
            end
            m_ghr = ng;
         end
      end
      #1;
   endtask

   task automatic idle();
      fv = 0; rv = 0; r_mis = 0; r_taken = 0; r_tag = '0; r_ghr = '0; f_tag = '0;
   endtask

   task automatic randomize_inputs(input bit allow_rdy_low);
      fv      = 1'($urandom_range(0, 1));
      f_tag   = IDX_W'($urandom_range(0, N-1));
      rv      = 1'($urandom_range(0, 1));
      r_tag   = IDX_W'($urandom_range(0, N-1));
      r_ghr   = HIST_W'($urandom_range(0, 255));
      r_taken = 1'($urandom_range(0, 1));
      r_mis   = ($urandom_range(0, 3) == 0);
      rdy     = allow_rdy_low ? ($urandom_range(0, 7) != 0) : 1'b1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_tbl[i] = 0;
      m_ready = 0; m_init = 0; m_ghr = 0; m_cnt = 0;
      rst = 1; rdy = 1; idle();
      repeat (2) @(posedge clk);
      #1;
      step();

      // reset release; init with a 10-cycle rdy=0 hole carrying traffic
      rst = 0;
      for (int i = 0; i < 5; i++) step();
      for (int i = 0; i < 10; i++) begin
         randomize_inputs(1'b0);
         rdy = 0;
         step();
      end
      rdy = 1; idle();
      for (int i = 0; i < 11; i++) begin
         chk("init_not_ready", out_ready, 1'b0);
         step();
      end
      chk("ready_after_16", out_ready, 1'b1);
      chk("ghr_after_init", out_fetch_ghr, 8'h00);
      for (int t = 0; t < N; t++) begin
         f_tag = IDX_W'(t);
         #1;
         chk("init_pred_nt", out_fetch_taken, 1'b0);
      end

      // train entry 5 up to strongly taken, then saturate
      idle();
      rv = 1; r_tag = 4'd5; r_ghr = 8'h00; r_taken = 1;
      step(); step();
      rv = 0; f_tag = 4'd5;
      #1 chk("t2_taken", out_fetch_taken, 1'b1);
      rv = 1; step();
      r_taken = 0; step();
      rv = 0; f_tag = 4'd5;
      #1 chk("t2_sat_hold", out_fetch_taken, 1'b1);

      // three speculative fetches predicting 1,0,1
      idle(); fv = 1;
      f_tag = 4'd5; #1 chk("t3_p0", out_fetch_taken, 1'b1); chk("t3_g0", out_fetch_ghr, 8'd0); step();
      f_tag = 4'd0; #1 chk("t3_p1", out_fetch_taken, 1'b0); chk("t3_g1", out_fetch_ghr, 8'd1); step();
      f_tag = 4'd7; #1 chk("t3_p2", out_fetch_taken, 1'b1); chk("t3_g2", out_fetch_ghr, 8'd2); step();
      fv = 0;
      chk("t3_ghr", out_fetch_ghr, 8'b101);

      // mispredict repair overrides same-cycle fetch shift
      fv = 1; f_tag = 4'd3;
      rv = 1; r_tag = 4'd0; r_ghr = 8'h0F; r_taken = 1; r_mis = 1;
      step();
      idle();
      chk("t4_ghr", out_fetch_ghr, 8'h1F);
      chk("t4_cnt", out_mispred_cnt, 2'd1);

      // stats counter saturates at all-ones
      for (int i = 0; i < 5; i++) begin
         rv = 1; r_mis = 1; r_tag = IDX_W'($urandom_range(0, N-1));
         r_ghr = HIST_W'($urandom_range(0, 255)); r_taken = 1'($urandom_range(0, 1));
         step();
      end
      idle();
      chk("t5_cnt_sat", out_mispred_cnt, 2'd3);

      // mispredict flag without valid is ignored
      rv = 0; r_mis = 1; r_ghr = 8'hAA; step();
      idle();
      chk("mis_no_valid_ghr", out_fetch_ghr, 8'h1F == 8'h00 ? 8'h00 : 8'(m_ghr));

      // randomized traffic with occasional rdy=0
      for (int i = 0; i < 400; i++) begin
         randomize_inputs(1'b1);
         step();
      end

      // reset while running restarts init and clears stats
      idle(); rdy = 1; rst = 1;
      step();
      rst = 0;
      chk("rst_run_cnt", out_mispred_cnt, 2'd0);
      chk("rst_run_ready", out_ready, 1'b0);
      chk("rst_run_ghr", out_fetch_ghr, 8'h00);
      for (int i = 0; i < N; i++) step();
      chk("reinit_ready", out_ready, 1'b1);
      for (int i = 0; i < 100; i++) begin
         randomize_inputs(1'b1);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
